// File: rtl/sec_scrub_ctrl.sv
// Shares one SEC corrector between host reads and a periodic background scrubber.
// Each op reads a 40-bit word, corrects it, returns the data and writes it back if data bits changed.
module sec_scrub_ctrl #(
  parameter int AW           = 10,
  parameter int SCRUB_PERIOD = 1024,
  parameter int MAX_DEFER    = 16
) (
  input  logic          blif_clk_net,
  input  logic          blif_reset_net,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  output logic          host_corrected,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  input  logic [39:0]   mem_rdata,
  output logic [39:0]   mem_wdata,
  output logic          sec_en,
  output logic [31:0]   sec_data,
  output logic [7:0]    sec_check,
  input  logic [31:0]   sec_out,
  output logic [15:0]   corr_cnt,
  output logic          busy,
  output logic [2:0]    fsm_state
);
  localparam int TW = $clog2(SCRUB_PERIOD);
  localparam int DW = $clog2(MAX_DEFER + 2);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_SEC, S_DONE} state_t;

  // Handshake: host_req/host_addr are held by the host until host_gnt; the request is
  // only sampled in S_IDLE, and host_rvalid pulses for exactly one cycle four cycles later.
  state_t          state_q, state_d;
  logic            op_scrub;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   scrub_addr;
  logic [39:0]     raw_q;
  logic [31:0]     cap_q;
  logic            diff_q;
  logic [TW-1:0]   timer_q;
  logic            scrub_pend;
  logic [DW-1:0]   defer_cnt;
  logic            start_scrub;

  assign start_scrub = (state_q == S_IDLE) && scrub_pend &&
                       ((defer_cnt >= DW'(MAX_DEFER)) || !host_req);

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_scrub || host_req) state_d = S_RD;
      S_RD:    state_d = S_WAIT;
      S_WAIT:  state_d = S_SEC;
      S_SEC:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      op_scrub   <= 1'b0;
      addr_q     <= '0;
      scrub_addr <= '0;
      raw_q      <= '0;
      cap_q      <= '0;
      diff_q     <= 1'b0;
      corr_cnt   <= '0;
      timer_q    <= TW'(SCRUB_PERIOD - 1);
      scrub_pend <= 1'b0;
      defer_cnt  <= '0;
    end else begin
      if (state_q == S_IDLE && state_d == S_RD) begin
        op_scrub <= start_scrub;
        addr_q   <= start_scrub ? scrub_addr : host_addr;
      end
      if (state_q == S_WAIT) raw_q <= mem_rdata;
      if (state_q == S_SEC) begin
        cap_q  <= sec_out;
        diff_q <= (sec_out != raw_q[31:0]);
      end
      if (state_q == S_DONE) begin
        if (diff_q && corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
        if (op_scrub) scrub_addr <= scrub_addr + AW'(1);
      end
      if (timer_q == '0) timer_q <= TW'(SCRUB_PERIOD - 1);
      else               timer_q <= timer_q - TW'(1);
      // An expiry while a scrub is already pending is simply absorbed.
      if (start_scrub)         scrub_pend <= 1'b0;
      else if (timer_q == '0)  scrub_pend <= 1'b1;
      if (start_scrub) defer_cnt <= '0;
      else if (scrub_pend && defer_cnt < DW'(MAX_DEFER)) defer_cnt <= defer_cnt + DW'(1);
    end
  end

  always_comb begin
    host_gnt       = 1'b0;
    host_rvalid    = 1'b0;
    host_rdata     = '0;
    host_corrected = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    sec_en         = 1'b0;
    unique case (state_q)
      S_RD: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        host_gnt = !op_scrub;
      end
      S_SEC: sec_en = 1'b1;
      S_DONE: begin
        if (!op_scrub) begin
          host_rvalid    = 1'b1;
          host_rdata     = cap_q;
          host_corrected = diff_q;
        end
        if (diff_q) begin
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = {raw_q[39:32], cap_q};
        end
      end
      default: ;
    endcase
  end

  // Corrector inputs come straight from the raw register, so they hold between ops.
  assign sec_data  = raw_q[31:0];
  assign sec_check = raw_q[39:32];
  assign busy      = (state_q != S_IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// Directed bench for sec_scrub_ctrl: a host-facing instance and a small fast-scrub instance,
// each with its own memory model and a behavioural SEC corrector.
module tb_sec_scrub_ctrl;
  localparam int AW  = 10;
  localparam int SAW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // main instance
  logic          host_req, host_gnt, host_rvalid, host_corrected;
  logic [AW-1:0] host_addr, mem_addr;
  logic [31:0]   host_rdata, sec_data, sec_out;
  logic          mem_rd, mem_wr, sec_en, busy;
  logic [39:0]   mem_rdata, mem_wdata;
  logic [7:0]    sec_check;
  logic [15:0]   corr_cnt;
  logic [2:0]    fsm_state;

  // small scrub instance
  logic           s_host_req, s_host_gnt, s_host_rvalid, s_host_corrected;
  logic [SAW-1:0] s_host_addr, s_mem_addr;
  logic [31:0]    s_host_rdata, s_sec_data, s_sec_out;
  logic           s_mem_rd, s_mem_wr, s_sec_en, s_busy;
  logic [39:0]    s_mem_rdata, s_mem_wdata;
  logic [7:0]     s_sec_check;
  logic [15:0]    s_corr_cnt;
  logic [2:0]     s_fsm_state;

  logic [39:0] mem   [0:(1<<AW)-1];
  logic [39:0] s_mem [0:(1<<SAW)-1];
  logic          pl_we, s_pl_we;
  logic [AW-1:0] pl_addr;
  logic [SAW-1:0] s_pl_addr;
  logic [39:0]   pl_data, s_pl_data;

  logic [144:0] outs;
  assign outs = {host_gnt, host_rvalid, host_rdata, host_corrected, mem_rd, mem_wr, mem_addr,
                 mem_wdata, sec_en, sec_data, sec_check, corr_cnt, busy};

  sec_scrub_ctrl #(.AW(AW), .SCRUB_PERIOD(1024), .MAX_DEFER(16)) dut (
    .blif_clk_net(clk), .blif_reset_net(rst),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_corrected(host_corrected),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .sec_en(sec_en), .sec_data(sec_data), .sec_check(sec_check),
    .sec_out(sec_out), .corr_cnt(corr_cnt), .busy(busy), .fsm_state(fsm_state)
  );

  sec_scrub_ctrl #(.AW(SAW), .SCRUB_PERIOD(8), .MAX_DEFER(16)) s_dut (
    .blif_clk_net(clk), .blif_reset_net(rst),
    .host_req(s_host_req), .host_addr(s_host_addr), .host_gnt(s_host_gnt),
    .host_rvalid(s_host_rvalid), .host_rdata(s_host_rdata), .host_corrected(s_host_corrected),
    .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
    .mem_wdata(s_mem_wdata), .sec_en(s_sec_en), .sec_data(s_sec_data), .sec_check(s_sec_check),
    .sec_out(s_sec_out), .corr_cnt(s_corr_cnt), .busy(s_busy), .fsm_state(s_fsm_state)
  );

  // Behavioural SEC code: data bit i contributes check pattern {2'b11, 1'b0, i}.
  function automatic logic [7:0] code_of(input int i);
    return {3'b110, 5'(i)};
  endfunction

  function automatic logic [7:0] calc_check(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c = c ^ code_of(i);
    return c;
  endfunction

  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] r;
    syn = c ^ calc_check(d);
    r   = d;
    for (int i = 0; i < 32; i++) if (syn == code_of(i)) r[i] = ~r[i];
    return r;
  endfunction

  assign sec_out   = sec_en   ? correct(sec_data, sec_check)     : 32'h0;
  assign s_sec_out = s_sec_en ? correct(s_sec_data, s_sec_check) : 32'h0;

  always @(posedge clk) begin
    if (pl_we)       mem[pl_addr] <= pl_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd)      mem_rdata <= mem[mem_addr];
    if (s_pl_we)       s_mem[s_pl_addr] <= s_pl_data;
    else if (s_mem_wr) s_mem[s_mem_addr] <= s_mem_wdata;
    if (s_mem_rd)      s_mem_rdata <= s_mem[s_mem_addr];
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [39:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic s_load(input logic [SAW-1:0] a, input logic [39:0] d);
    s_pl_addr = a; s_pl_data = d; s_pl_we = 1'b1;
    tick();
    s_pl_we = 1'b0;
  endtask

  // Issues one host read; k counts cycles after the edge that samples host_req.
  task automatic host_read(input logic [AW-1:0] a, output logic [31:0] rdata, output logic corr,
                           output int gnt_k, output int sec_k, output int rv_k, output int wr_k,
                           output logic [AW-1:0] wr_addr, output logic [39:0] wr_word,
                           output int idle_k, output logic overlap);
    gnt_k = -1; sec_k = -1; rv_k = -1; wr_k = -1; idle_k = -1;
    overlap = 1'b0; rdata = '0; corr = 1'b0; wr_addr = '0; wr_word = '0;
    host_addr = a;
    host_req  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (host_gnt && gnt_k < 0) begin gnt_k = k; host_req = 1'b0; end
      if (sec_en && sec_k < 0) sec_k = k;
      if (host_rvalid && rv_k < 0) begin rv_k = k; rdata = host_rdata; corr = host_corrected; end
      if (mem_wr && wr_k < 0) begin wr_k = k; wr_addr = mem_addr; wr_word = mem_wdata; end
      if (mem_rd && mem_wr) overlap = 1'b1;
      if (!busy && gnt_k > 0 && idle_k < 0) idle_k = k;
    end
    host_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    n_cmp++; if (fsm_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_no_error();
    logic [31:0] rd; logic corr, ov; int g, s, r, w, idl; logic [AW-1:0] wa; logic [39:0] ww;
    load(10'd5, {calc_check(32'hDEADBEEF), 32'hDEADBEEF});
    host_read(10'd5, rd, corr, g, s, r, w, wa, ww, idl, ov);
    n_cmp++; if (g !== 1) begin n_bad++; $display("FAIL clean_gnt_cycle got=%0d exp=1", g); end
    n_cmp++; if (s !== 3) begin n_bad++; $display("FAIL clean_sec_cycle got=%0d exp=3", s); end
    n_cmp++; if (r !== 4) begin n_bad++; $display("FAIL clean_rvalid_cycle got=%0d exp=4", r); end
    n_cmp++; if (idl !== 5) begin n_bad++; $display("FAIL clean_idle_cycle got=%0d exp=5", idl); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL clean_rdata got=%h exp=deadbeef", rd); end
    n_cmp++; if (corr !== 1'b0) begin n_bad++; $display("FAIL clean_corrected got=%b exp=0", corr); end
    n_cmp++; if (w !== -1) begin n_bad++; $display("FAIL clean_no_write got=%0d exp=-1", w); end
    n_cmp++; if (corr_cnt !== 16'd0) begin n_bad++; $display("FAIL clean_corr_cnt got=%0d exp=0", corr_cnt); end
  endtask

  task automatic test_single_bit();
    logic [31:0] rd; logic corr, ov; int g, s, r, w, idl; logic [AW-1:0] wa; logic [39:0] ww;
    logic [39:0] good;
    good = {calc_check(32'hDEADBEEF), 32'hDEADBEEF};
    load(10'd5, {good[39:32], 32'hDEADBEEF ^ (32'h1 << 17)});
    host_read(10'd5, rd, corr, g, s, r, w, wa, ww, idl, ov);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sbe_rdata got=%h exp=deadbeef", rd); end
    n_cmp++; if (corr !== 1'b1) begin n_bad++; $display("FAIL sbe_corrected got=%b exp=1", corr); end
    n_cmp++; if (w !== 4) begin n_bad++; $display("FAIL sbe_wr_cycle got=%0d exp=4", w); end
    n_cmp++; if (wa !== 10'd5) begin n_bad++; $display("FAIL sbe_wr_addr got=%0d exp=5", wa); end
    n_cmp++; if (ww !== good) begin n_bad++; $display("FAIL sbe_wr_word got=%h exp=%h", ww, good); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL sbe_rd_wr_overlap got=%b exp=0", ov); end
    n_cmp++; if (corr_cnt !== 16'd1) begin n_bad++; $display("FAIL sbe_corr_cnt got=%0d exp=1", corr_cnt); end
    n_cmp++; if (mem[5] !== good) begin n_bad++; $display("FAIL sbe_mem_fixed got=%h exp=%h", mem[5], good); end
  endtask

  task automatic test_check_only();
    logic [31:0] rd; logic corr, ov; int g, s, r, w, idl; logic [AW-1:0] wa; logic [39:0] ww;
    load(10'd6, {calc_check(32'h12345678) ^ 8'h01, 32'h12345678});
    host_read(10'd6, rd, corr, g, s, r, w, wa, ww, idl, ov);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL chk_rdata got=%h exp=12345678", rd); end
    n_cmp++; if (corr !== 1'b0) begin n_bad++; $display("FAIL chk_corrected got=%b exp=0", corr); end
    n_cmp++; if (w !== -1) begin n_bad++; $display("FAIL chk_no_write got=%0d exp=-1", w); end
    n_cmp++; if (corr_cnt !== 16'd1) begin n_bad++; $display("FAIL chk_corr_cnt got=%0d exp=1", corr_cnt); end
  endtask

  task automatic test_back_to_back();
    int g1, g2, r1, r2;
    logic [31:0] d1, d2;
    g1 = -1; g2 = -1; r1 = -1; r2 = -1; d1 = '0; d2 = '0;
    load(10'd8, {calc_check(32'hCAFE0008), 32'hCAFE0008});
    load(10'd9, {calc_check(32'h0000F009), 32'h0000F009});
    host_addr = 10'd8;
    host_req  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (host_gnt) begin
        if (g1 < 0) begin g1 = k; host_addr = 10'd9; end
        else if (g2 < 0) begin g2 = k; host_req = 1'b0; end
      end
      if (host_rvalid) begin
        if (r1 < 0) begin r1 = k; d1 = host_rdata; end
        else if (r2 < 0) begin r2 = k; d2 = host_rdata; end
      end
    end
    host_req = 1'b0;
    n_cmp++; if (g2 !== 6) begin n_bad++; $display("FAIL b2b_second_gnt got=%0d exp=6", g2); end
    n_cmp++; if (r2 !== 9) begin n_bad++; $display("FAIL b2b_second_rvalid got=%0d exp=9", r2); end
    n_cmp++; if (d1 !== 32'hCAFE0008) begin n_bad++; $display("FAIL b2b_data1 got=%h exp=cafe0008", d1); end
    n_cmp++; if (d2 !== 32'h0000F009) begin n_bad++; $display("FAIL b2b_data2 got=%h exp=0000f009", d2); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic corr, ov; int g, s, r, w, idl; logic [AW-1:0] wa; logic [39:0] ww;
    logic [31:0] flips [3];
    logic [15:0] exp_cnt [3];
    flips[0] = 32'h0000_0001; flips[1] = 32'h8000_0000; flips[2] = 32'h0002_0000;
    exp_cnt[0] = 16'hFFFF; exp_cnt[1] = 16'hFFFF; exp_cnt[2] = 16'hFFFF;
    dut.corr_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      load(10'd5, {calc_check(32'hDEADBEEF), 32'hDEADBEEF ^ flips[i]});
      host_read(10'd5, rd, corr, g, s, r, w, wa, ww, idl, ov);
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sat_rdata[%0d] got=%h exp=deadbeef", i, rd); end
      n_cmp++; if (corr_cnt !== exp_cnt[i]) begin n_bad++; $display("FAIL sat_corr_cnt[%0d] got=%h exp=%h", i, corr_cnt, exp_cnt[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic corr, ov; int g, s, r, w, idl; logic [AW-1:0] wa; logic [39:0] ww;
    int stray;
    load(10'd7, {calc_check(32'h0BADF00D), 32'h0BADF00D ^ 32'h8});
    host_addr = 10'd7;
    host_req  = 1'b1;
    tick();
    host_req = 1'b0;
    tick();
    tick();
    n_cmp++; if (sec_en !== 1'b1) begin n_bad++; $display("FAIL mid_in_sec got=%b exp=1", sec_en); end
    rst = 1'b1;
    tick();
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL mid_reset_outputs got=%h exp=0", outs); end
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (host_rvalid || mem_wr || mem_rd) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mid_no_stray_activity got=%0d exp=0", stray); end
    host_read(10'd7, rd, corr, g, s, r, w, wa, ww, idl, ov);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL mid_reread_data got=%h exp=0badf00d", rd); end
    n_cmp++; if (w !== 4) begin n_bad++; $display("FAIL mid_reread_wr_cycle got=%0d exp=4", w); end
    n_cmp++; if (corr_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_corr_cnt got=%0d exp=1", corr_cnt); end
  endtask

  task automatic test_scrub();
    logic [SAW-1:0] exp_q [$];
    int             exp_k [$];
    int             wr_n, ek;
    logic [SAW-1:0] ea;
    logic [39:0]    good2;
    rst = 1'b1;
    s_host_req = 1'b0;
    for (int i = 0; i < 4; i++) s_load(SAW'(i), {calc_check(32'hA5A50000 + i), 32'hA5A50000 + i});
    good2 = {calc_check(32'hA5A50002), 32'hA5A50002};
    s_load(2'd2, {good2[39:32], good2[31:0] ^ 32'h0000_4000});
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(SAW'(i % 4));
      exp_k.push_back(9 + 8 * i);
    end
    rst  = 1'b0;
    wr_n = 0;
    for (int k = 1; k <= 60 && exp_q.size() > 0; k++) begin
      tick();
      if (s_mem_wr) begin
        wr_n++;
        n_cmp++; if (s_mem_addr !== 2'd2 || s_mem_wdata !== good2) begin
          n_bad++; $display("FAIL scrub_writeback got=%0d/%h exp=2/%h", s_mem_addr, s_mem_wdata, good2);
        end
      end
      if (s_mem_rd) begin
        ea = exp_q.pop_front();
        ek = exp_k.pop_front();
        n_cmp++; if (s_mem_addr !== ea) begin n_bad++; $display("FAIL scrub_addr got=%0d exp=%0d", s_mem_addr, ea); end
        n_cmp++; if (k !== ek) begin n_bad++; $display("FAIL scrub_cycle got=%0d exp=%0d", k, ek); end
        n_cmp++; if (s_host_gnt !== 1'b0) begin n_bad++; $display("FAIL scrub_no_host_gnt got=%b exp=0", s_host_gnt); end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scrub_timeout got=%0d left exp=0", exp_q.size()); end
    n_cmp++; if (wr_n !== 1) begin n_bad++; $display("FAIL scrub_write_count got=%0d exp=1", wr_n); end
    n_cmp++; if (s_corr_cnt !== 16'd1) begin n_bad++; $display("FAIL scrub_corr_cnt got=%0d exp=1", s_corr_cnt); end
  endtask

  task automatic test_starvation();
    int scrub_k, resume_k, host_n;
    scrub_k = -1; resume_k = -1; host_n = 0;
    rst = 1'b1;
    tick();
    s_host_addr = 2'd1;
    s_host_req  = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 45 && resume_k < 0; k++) begin
      tick();
      if (s_mem_rd && !s_host_gnt && scrub_k < 0) scrub_k = k;
      if (s_host_gnt) begin
        if (scrub_k < 0) host_n++;
        else if (resume_k < 0) resume_k = k;
      end
    end
    s_host_req = 1'b0;
    n_cmp++; if (scrub_k !== 26) begin n_bad++; $display("FAIL starve_scrub_cycle got=%0d exp=26", scrub_k); end
    n_cmp++; if (host_n !== 5) begin n_bad++; $display("FAIL starve_host_ops_before got=%0d exp=5", host_n); end
    n_cmp++; if (resume_k !== 31) begin n_bad++; $display("FAIL starve_host_resume got=%0d exp=31", resume_k); end
  endtask

  initial begin
    rst = 1'b1;
    host_req = 1'b0; host_addr = '0;
    s_host_req = 1'b0; s_host_addr = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    s_pl_we = 1'b0; s_pl_addr = '0; s_pl_data = '0;
    test_reset();
    test_no_error();
    test_single_bit();
    test_check_only();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_scrub();
    test_starvation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
